// File: rtl/cpu_pkg.sv
// Shared types and constants for the execute->memory boundary.
// The ALU result, store data and flags travel together as one ex_entry_t.
package cpu_pkg;

  localparam int DW = 48;
  localparam int AW = 4;
  localparam int FW = 4;

  // Flag bit positions: [3] B>A, [2] zero, [1] reserved (always 0), [0] other.
  localparam int FLAG_GT    = 3;
  localparam int FLAG_Z     = 2;
  localparam int FLAG_RSVD  = 1;
  localparam int FLAG_OTHER = 0;

  typedef struct packed {
    logic          reg_write;
    logic          mem_write;
    logic          mem_to_reg;
    logic          flag_write;
    logic [AW-1:0] wa3;
  } ex_ctrl_t;

  typedef struct packed {
    ex_ctrl_t      ctrl;
    logic [DW-1:0] result;
    logic [DW-1:0] wdata;
    logic [FW-1:0] flags;
  } ex_entry_t;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry in-order FIFO with occupancy count and synchronous flush.
// slot0 is always the head; a pop shifts slot1 forward.
module skid_fifo2 #(
  parameter type T = logic [7:0]
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  T           din,
  input  logic       pop,
  output T           dout,
  output logic       valid,
  output logic [1:0] count
);

  T     slot0;
  T     slot1;
  logic pop_ok;
  logic push_ok;

  assign pop_ok  = pop & (count != 2'd0);
  assign push_ok = push & ((count != 2'd2) | pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) slot0 <= din;
          else               slot1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push and pop: occupancy unchanged, order preserved.
          if (count == 2'd2) begin
            slot0 <= slot1;
            slot1 <= din;
          end else begin
            slot0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = slot0;
  assign valid = (count != 2'd0);

endmodule

// File: rtl/ex_mem_stage.sv
// Execute->memory boundary: aligns issue-time control with the registered ALU
// result, buffers entries in a 2-entry FIFO and holds the architectural flags.
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int DW = cpu_pkg::DW,
  parameter int AW = cpu_pkg::AW,
  parameter int FW = cpu_pkg::FW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          RegWriteE,
  input  logic          MemWriteE,
  input  logic          MemtoRegE,
  input  logic          FlagWriteE,
  input  logic [AW-1:0] WA3E,
  input  logic [DW-1:0] WriteDataE,
  input  logic [DW-1:0] ALUResultE,
  input  logic [FW-1:0] ALUFlags,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          RegWriteM,
  output logic          MemWriteM,
  output logic          MemtoRegM,
  output logic [AW-1:0] WA3M,
  output logic [DW-1:0] ALUOutM,
  output logic [DW-1:0] WriteDataM,
  output logic [FW-1:0] FlagsM
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high. valid never depends on ready; ready here depends only on registers.

  logic          align_valid;
  ex_ctrl_t      align_ctrl;
  logic [DW-1:0] align_wdata;
  logic [1:0]    count;
  logic [2:0]    occupancy;
  logic          issue;
  logic          pop;
  ex_entry_t     push_entry;
  ex_entry_t     head;

  // The align slot plus FIFO entries never exceed the FIFO depth, so the push
  // out of the align slot always has room even if the head is not popped.
  assign occupancy = {1'b0, count} + {2'b00, align_valid};
  assign in_ready  = (occupancy < 3'd2);
  assign issue     = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_valid <= 1'b0;
      align_ctrl  <= '0;
      align_wdata <= '0;
    end else begin
      align_valid <= issue;
      if (issue) begin
        align_ctrl.reg_write  <= RegWriteE;
        align_ctrl.mem_write  <= MemWriteE;
        align_ctrl.mem_to_reg <= MemtoRegE;
        align_ctrl.flag_write <= FlagWriteE;
        align_ctrl.wa3        <= WA3E;
        align_wdata           <= WriteDataE;
      end
    end
  end

  always_comb begin
    push_entry                  = '0;
    push_entry.ctrl             = align_ctrl;
    push_entry.result           = ALUResultE;
    push_entry.wdata            = align_wdata;
    push_entry.flags            = ALUFlags;
    push_entry.flags[FLAG_RSVD] = 1'b0;
  end

  skid_fifo2 #(
    .T (ex_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (align_valid),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .valid (out_valid),
    .count (count)
  );

  // Flags commit only when an entry leaves; a same-cycle flush does not cancel it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      FlagsM <= '0;
    end else if (pop && head.ctrl.flag_write) begin
      FlagsM <= head.flags;
    end
  end

  assign RegWriteM  = head.ctrl.reg_write;
  assign MemWriteM  = head.ctrl.mem_write;
  assign MemtoRegM  = head.ctrl.mem_to_reg;
  assign WA3M       = head.ctrl.wa3;
  assign ALUOutM    = head.result;
  assign WriteDataM = head.wdata;

endmodule
